// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = x * y * 2^-WIDTH mod n.
// Runs once after reset release and holds its result until the next reset.
module mont_mul #(
  parameter int WIDTH = 2048
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] s_acc;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] n_q;

  logic load_en;
  logic iter_en;
  logic final_en;

  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;
  logic [WIDTH+1:0] s_nxt;

  // Conditional subtract that brings S from [0, 2n) into [0, n).
  function automatic logic [WIDTH-1:0] final_reduce(
    input logic [WIDTH+1:0] s_val,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] diff;
    m_ext = {2'b00, m};
    diff  = s_val - m_ext;
    if (s_val >= m_ext)
      return diff[WIDTH-1:0];
    else
      return s_val[WIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = ITER;
      ITER:    state_nxt = (cnt == LAST_ITER) ? FINAL : ITER;
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  // Output / control decode
  always_comb begin
    load_en  = 1'b0;
    iter_en  = 1'b0;
    final_en = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD:    load_en  = 1'b1;
      ITER:    iter_en  = 1'b1;
      FINAL:   final_en = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  // Operand capture; x is consumed LSB first by shifting it right each iteration.
  always_ff @(posedge clk) begin
    if (load_en) begin
      x_sh <= x;
      y_q  <= y;
      n_q  <= n;
    end else if (iter_en) begin
      x_sh <= x_sh >> 1;
    end
  end

  // One Montgomery step; WIDTH+2 bits hold S + y + n without overflow even for invalid operands.
  always_comb begin
    t_add = s_acc + (x_sh[0] ? {2'b00, y_q} : '0);
    t_odd = t_add + (t_add[0] ? {2'b00, n_q} : '0);
    s_nxt = {1'b0, t_odd[WIDTH+1:1]};
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt    <= '0;
      s_acc  <= '0;
      result <= '0;
    end else begin
      if (load_en) begin
        cnt   <= '0;
        s_acc <= '0;
      end else if (iter_en) begin
        cnt   <= cnt + 1'b1;
        s_acc <= s_nxt;
      end
      if (final_en)
        result <= final_reduce(s_acc, n_q);
    end
  end

endmodule

// File: tb/tb_mont_mul.sv
// Directed bench for mont_mul: an 8-bit instance for functional cases and a
// 2048-bit instance for full-width latency, with a result scoreboard queue.
module tb_mont_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst8;
  logic [7:0]   x8, y8, n8;
  logic [7:0]   res8;
  logic         done8;

  logic            rstw;
  logic [2047:0]   xw, yw, nw;
  logic [2047:0]   resw;
  logic            donew;

  mont_mul #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .sys_rst(rst8),
    .x      (x8),
    .y      (y8),
    .n      (n8),
    .result (res8),
    .done   (done8)
  );

  mont_mul #(.WIDTH(2048)) dutw (
    .clk    (clk),
    .sys_rst(rstw),
    .x      (xw),
    .y      (yw),
    .n      (nw),
    .result (resw),
    .done   (donew)
  );

  int checks = 0;
  int errors = 0;
  logic [2047:0] sb_q[$];

  task automatic check(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // x*y*2^-8 mod n, computed as (x*y mod n) followed by eight modular halvings.
  function automatic int mont_ref(input int xv, input int yv, input int nv);
    int r;
    r = (xv * yv) % nv;
    for (int k = 0; k < 8; k++)
      r = (r % 2 == 1) ? (r + nv) / 2 : r / 2;
    return r;
  endfunction

  // Reset (asynchronously, from wherever the DUT is), then run one full operation.
  task automatic run8(input int xv, input int yv, input int nv, input string tag);
    logic [2047:0] exp;
    rst8 = 1'b0;
    #1;
    check({tag, "_rst_done"}, {2047'b0, done8}, '0);
    check({tag, "_rst_result"}, {2040'b0, res8}, '0);
    x8 = 8'(xv);
    y8 = 8'(yv);
    n8 = 8'(nv);
    @(negedge clk);
    sb_q.push_back(2048'(mont_ref(xv, yv, nv)));
    rst8 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        x8 = ~x8;
        y8 = ~y8;
        n8 = ~n8;
      end
      if (c < 10)
        check({tag, "_done_early"}, {2047'b0, done8}, '0);
    end
    check({tag, "_done"}, {2047'b0, done8}, 2048'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_result"}, {2040'b0, res8}, exp);
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, {2047'b0, done8}, 2048'd1);
    check({tag, "_hold_result"}, {2040'b0, res8}, 2048'(mont_ref(xv, yv, nv)));
  endtask

  initial begin
    int xv, yv, nv;
    logic [2047:0] expw;
    rst8 = 1'b0;
    rstw = 1'b0;
    x8 = '0; y8 = '0; n8 = 8'd3;
    xw = '0; yw = '0; nw = '0;

    repeat (2) @(posedge clk);

    run8(5, 7, 11, "x5y7n11");
    check("x5y7n11_const", {2040'b0, res8}, 2048'd8);
    run8(10, 20, 33, "x10y20n33");
    check("x10y20n33_const", {2040'b0, res8}, 2048'd8);
    run8(55, 27, 33, "x55y27n33");
    check("x55y27n33_const", {2040'b0, res8}, 2048'd0);
    run8(0, 20, 33, "x0y20n33");
    check("x0y20n33_const", {2040'b0, res8}, 2048'd0);
    run8(200, 0, 251, "x200y0");
    run8(255, 254, 255, "max");

    for (int k = 0; k < 4; k++) begin
      nv = $urandom_range(1, 127) * 2 + 1;
      yv = $urandom_range(0, nv - 1);
      xv = $urandom_range(0, 255);
      run8(xv, yv, nv, "rand");
    end

    // Abort mid-ITER, then restart with different operands.
    rst8 = 1'b0;
    x8 = 8'd10; y8 = 8'd20; n8 = 8'd33;
    @(negedge clk);
    rst8 = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst8 = 1'b0;
    #1;
    check("abort_done", {2047'b0, done8}, '0);
    check("abort_result", {2040'b0, res8}, '0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_held_done", {2047'b0, done8}, '0);
    run8(5, 7, 11, "after_abort");

    // Full width: n = 2^2047 + 1, x = y = 0, inputs scrambled after LOAD.
    nw = '0;
    nw[2047] = 1'b1;
    nw[0] = 1'b1;
    @(negedge clk);
    check("w_rst_done", {2047'b0, donew}, '0);
    check("w_rst_result", resw, '0);
    sb_q.push_back('0);
    rstw = 1'b1;
    for (int c = 1; c <= 2050; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        xw = {64{$urandom()}};
        yw = {64{$urandom()}} | 2048'd1;
        nw = ~nw;
      end
      if (c == 2049)
        check("w_done_early", {2047'b0, donew}, '0);
    end
    check("w_done", {2047'b0, donew}, 2048'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL w_sb observed=empty expected=entry");
    end else begin
      expw = sb_q.pop_front();
      check("w_result", resw, expw);
    end
    repeat (2) @(posedge clk);
    #1;
    check("w_hold_done", {2047'b0, donew}, 2048'd1);
    rstw = 1'b0;
    #1;
    check("w_async_rst_done", {2047'b0, donew}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_mul.md
Name: mont_mul

Overview:
- Radix-2 bit-serial Montgomery modular multiplier.
- Computes result = x * y * 2^(-WIDTH) mod n for an odd modulus n. Default width is 2048, for RSA modular exponentiation.
- Starts automatically when reset is released and needs no start strobe. The result is held until the next reset.
- Used as the core multiply step of the RSA datapath.

Parameters:
- WIDTH, 2048, operand/modulus/result width in bits. This is also the Montgomery iteration count, so R = 2^WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- sys_rst  input  1  reset; asynchronous, active-low.
- x  input  WIDTH  multiplier operand, any value below 2^WIDTH.
- y  input  WIDTH  multiplicand; must satisfy y < n.
- n  input  WIDTH  modulus; must be odd, n >= 3.
- result  output  WIDTH  Montgomery product, valid while done=1.
- done  output  1  high when result is valid; may be left unconnected.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - result=0, done=0, accumulator S=0, iteration counter=0, state=LOAD.
  - Reset asserted mid-operation aborts immediately. No partial result is retained.
- States: LOAD -> ITER -> FINAL -> DONE.
- LOAD (first rising edge with sys_rst=1):
  - Register x, y and n internally. Later input changes are ignored until the next reset.
  - Set S=0 and i=0.
- ITER (WIDTH cycles, i = 0..WIDTH-1, LSB of x first). Each cycle:
  - T = S + (x[i] ? y : 0).
  - If T is odd, T = T + n.
  - S = T >> 1.
  - S, T need WIDTH+2 bits; no truncation is allowed.
  - Invariant: S < 2n whenever y < n.
  - After i = WIDTH-1, go to FINAL.
- FINAL (1 cycle): result = (S >= n) ? S - n : S, truncated to WIDTH bits.
- DONE:
  - done=1. result and done hold indefinitely; no further computation.
  - A new operation requires a reset pulse.
- Latency: done rises on the (WIDTH+2)th rising edge after sys_rst deasserts, i.e. 2050 cycles at default width.
- Invalid operands (y >= n, or n even): result is unspecified, but the FSM must still reach DONE with the same latency and must not hang.
- x = 0 or y = 0 gives result 0.
- Only one clock; no combinational path from inputs to result.
- Implementation guidance (optional): a single WIDTH+2-bit adder plus a comparator/subtractor is acceptable; a carry-save implementation is also allowed if latency is preserved.

Test Plan:
- WIDTH=8, x=5, y=7, n=11, release reset:
  - done=0 through cycle 9; done=1 at cycle 10.
  - result=8 (35 * 256^-1 mod 11).
- WIDTH=8, x=10, y=20, n=33 -> result=8 (200 * 4 mod 33).
- WIDTH=8, x=55, y=27, n=33 -> result=0 (1485 ≡ 0 mod 33); exercises an input x > n.
- WIDTH=8, x=0, y=20, n=33 -> result=0, done=1 after 10 cycles.
- Reset mid-operation:
  - WIDTH=8, x=10, y=20, n=33. Assert sys_rst=0 during ITER cycle 4.
  - Expect result=0 and done=0 immediately (asynchronous).
  - Change x to 5 and n to 11 (y=7), then release reset: result=8 after 10 cycles.
- WIDTH=2048, n = 2^2047+1, x=y=0, release reset:
  - done=1 exactly 2050 cycles after release, result=0.
  - Inputs changed after LOAD do not affect result.
